mem_wb_result_stage: RTL
========================

Name: mem_wb_result_stage

Overview:
- Parametrised MEM/WB pipeline register with write-back result selection.
- Generalises the single 2:1 memory-vs-ALU write-back select to a 4-source select (ALU, memory, link, upper-immediate).
- Adds sub-word load formatting, stall/flush control and register-file write-enable qualification.
- Sits between data memory and the register file. Its registered outputs also feed the EX-stage forwarding unit.

Parameters:
- DATA_W, 32, datapath width; must be 32 for byte/half formatting, wider values unsupported.
- REG_AW, 5, register-file address width.
- ZERO_REG_GUARD, 1, when 1 writes to register 0 are suppressed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  MEM-stage instruction valid.
- stall  input  1  hold stage contents.
- flush  input  1  invalidate stage.
- alu_result  input  DATA_W  ALU result / memory address.
- mem_rd  input  DATA_W  raw word from data memory.
- link_addr  input  DATA_W  return address (PC+8).
- imm_upper  input  DATA_W  LUI value.
- result_sel  input  2  0=ALU, 1=MEM, 2=LINK, 3=IMM.
- load_size  input  2  0=byte, 1=half, 2/3=word.
- load_signed  input  1  sign-extend sub-word loads.
- reg_write  input  1  instruction writes the register file.
- dest_reg  input  REG_AW  destination register.
- wb_valid  output  1  stage holds a valid instruction.
- wb_we  output  1  register-file write enable.
- wb_rd  output  REG_AW  write address.
- wb_data  output  DATA_W  write data.

Behaviour:
- One register stage; latency 1 cycle from capture to outputs.
- Captured fields: valid, alu_result, mem_rd, link_addr, imm_upper, result_sel, load_size, load_signed, reg_write, dest_reg.
- Capture priority each rising edge:
  - flush=1: valid<=0; other fields don't-care, may hold.
  - else stall=1: all fields hold.
  - else: all fields <= inputs; valid<=in_valid.
- flush wins over stall when both are asserted.
- rst_n low (asynchronous, any time, including mid-stall): valid=0 and every stored field =0.
  - Hence outputs under reset: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
- Outputs are combinational from stored fields only; no input-to-output path.
- wb_valid = stored valid.
- wb_rd = stored dest_reg.
- wb_we = valid & reg_write & ~(ZERO_REG_GUARD & (dest_reg==0)).
- wb_data by stored result_sel: 0 alu_result; 1 formatted load; 2 link_addr; 3 imm_upper.
- wb_data is driven even when wb_we=0 (not forced to zero).
- Load formatting uses little-endian byte lanes; offset = stored alu_result[1:0].
  - Byte: lane = mem_rd[8*offset+7 : 8*offset]; sign- or zero-extended to 32 bits per load_signed.
  - Half: lane = offset[1] ? mem_rd[31:16] : mem_rd[15:0]; offset[0] is ignored (misalignment is trapped upstream); extended per load_signed.
  - Word (2 or 3): mem_rd unchanged; offset and load_signed ignored.
- Stall holds wb_* stable every stalled cycle. The register file may see repeated identical writes; this is harmless.
- Release from stall resumes capture on the next edge; there is no bubble and no duplication beyond the held value.

Test Plan:
- Reset: rst_n=0 mid-run with valid data stored -> same cycle, without waiting for a clock edge, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
- ALU path: in_valid=1, sel=0, alu_result=0x0000_1234, reg_write=1, dest=8 -> next cycle wb_we=1, wb_rd=8, wb_data=0x0000_1234.
- Load byte: sel=1, mem_rd=0x80FF_7F01, alu_result low bits=3.
  - Signed -> wb_data=0xFFFF_FF80.
  - Offset 2, unsigned -> 0x0000_00FF.
  - Half, offset 2, signed -> 0xFFFF_80FF.
  - Word -> 0x80FF_7F01.
- Link/IMM: sel=2, link_addr=0x0040_0008 -> wb_data=0x0040_0008; sel=3, imm_upper=0xABCD_0000 -> 0xABCD_0000.
- Zero guard: reg_write=1, dest=0, valid -> wb_valid=1, wb_we=0. Same case with ZERO_REG_GUARD=0 -> wb_we=1.
- Stall/flush:
  - Stall 3 cycles while inputs change -> outputs frozen at the pre-stall instruction.
  - stall=1 and flush=1 together -> next cycle wb_valid=0, wb_we=0.
  - Release -> the next valid input appears one cycle later.

Source files
------------

// File: rtl/mem_wb_result_stage.sv
// MEM/WB pipeline register with four-source write-back select, sub-word
// load formatting, stall/flush control and register-file write qualification.
// The registered outputs also feed the EX-stage forwarding unit.

// Little-endian load formatter: picks the byte or half lane addressed by the
// low address bits and sign- or zero-extends it. Word loads pass through.
module mem_wb_load_fmt #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_sign;
  logic        half_sign;

  // Lane extraction from the addressed byte/half position.
  always_comb begin
    byte_lane = raw_i[7:0];
    case (offset_i)
      2'd0: byte_lane = raw_i[7:0];
      2'd1: byte_lane = raw_i[15:8];
      2'd2: byte_lane = raw_i[23:16];
      2'd3: byte_lane = raw_i[31:24];
      default: byte_lane = raw_i[7:0];
    endcase
    // offset[0] is ignored for halves; misaligned halves trap upstream.
    half_lane = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  assign byte_sign = signed_i & byte_lane[7];
  assign half_sign = signed_i & half_lane[15];

  // Extension by access size; sizes 2 and 3 are both full-word loads.
  always_comb begin
    data_o = raw_i;
    case (size_i)
      2'd0:    data_o = {{(DATA_W-8){byte_sign}}, byte_lane};
      2'd1:    data_o = {{(DATA_W-16){half_sign}}, half_lane};
      default: data_o = raw_i;
    endcase
  end

endmodule

module mem_wb_result_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] link_addr,
  input  logic [DATA_W-1:0] imm_upper,
  input  logic [1:0]        result_sel,
  input  logic [1:0]        load_size,
  input  logic              load_signed,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic GUARD = (ZERO_REG_GUARD != 0);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_IMM  = 2'd3;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [DATA_W-1:0] mem_q,    mem_d;
  logic [DATA_W-1:0] link_q,   link_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [1:0]        sel_q,    sel_d;
  logic [1:0]        size_q,   size_d;
  logic              sgn_q,    sgn_d;
  logic              rw_q,     rw_d;
  logic [REG_AW-1:0] rd_q,     rd_d;

  logic [DATA_W-1:0] load_data;
  logic              rd_is_zero;

  // Next-state: flush kills the valid bit (payload may hold), stall holds
  // everything, otherwise capture the MEM-stage instruction.
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    link_d  = link_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      alu_d   = alu_result;
      mem_d   = mem_rd;
      link_d  = link_addr;
      imm_d   = imm_upper;
      sel_d   = result_sel;
      size_d  = load_size;
      sgn_d   = load_signed;
      rw_d    = reg_write;
      rd_d    = dest_reg;
    end
  end

  // Stage register; asynchronous reset clears every field, so all outputs
  // read zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      link_q  <= '0;
      imm_q   <= '0;
      sel_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      link_q  <= link_d;
      imm_q   <= imm_d;
      sel_q   <= sel_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
    end
  end

  // Load formatting works on the stored word and stored address low bits.
  mem_wb_load_fmt #(
    .DATA_W (DATA_W)
  ) u_load_fmt (
    .raw_i    (mem_q),
    .offset_i (alu_q[1:0]),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (load_data)
  );

  assign rd_is_zero = (rd_q == '0);

  // Outputs depend on stored state only; no input reaches an output
  // combinationally, which keeps the forwarding path timing clean.
  always_comb begin
    wb_valid = valid_q;
    wb_rd    = rd_q;
    wb_we    = valid_q & rw_q & ~(GUARD & rd_is_zero);
    // Data is driven regardless of wb_we so forwarding sees it unchanged.
    wb_data  = alu_q;
    case (sel_q)
      SEL_ALU:  wb_data = alu_q;
      SEL_MEM:  wb_data = load_data;
      SEL_LINK: wb_data = link_q;
      SEL_IMM:  wb_data = imm_q;
      default:  wb_data = alu_q;
    endcase
  end

endmodule
